// File: rtl/multi_src_injector_pkg.sv
// Shared types for the multi-source NoC injector.
// Holds the arbiter FSM state type and the default flit width.
package PhiversPkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } inj_state_t;

   localparam int FLIT_SIZE_DEFAULT = 32;

endpackage

// File: rtl/multi_src_injector_fifo.sv
// inj_fifo: per-source flit buffer, power-of-two depth, first-word-fall-through.
// Ports: clk_i, rst_i, push_i/din_i, pop_i/dout_o, empty_o, full_o.
module inj_fifo
   import PhiversPkg::*;
#(
   parameter int WIDTH = FLIT_SIZE_DEFAULT + 1,
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] din_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count == '0);
   assign full_o  = (count == (AW+1)'(DEPTH));
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= din_i;
   end

endmodule

// File: rtl/multi_src_injector.sv
// multi_src_injector: round-robin packet arbiter from N_SRC source FIFOs to one NoC port.
// Ports: src_tx_i/src_eop_i/src_data_i/src_credit_o (sources), tx_o/credit_i/data_o (NoC);
// macro MULTI_SRC_INJECTOR_STATS_EN adds pkt_count_o (per-source eop counters).
module multi_src_injector
   import PhiversPkg::*;
#(
   parameter int N_SRC      = 2,
   parameter int FLIT_SIZE  = FLIT_SIZE_DEFAULT,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [N_SRC-1:0]          src_tx_i,
   input  logic [N_SRC-1:0]          src_eop_i,
   input  logic [N_SRC*FLIT_SIZE-1:0] src_data_i,
   output logic [N_SRC-1:0]          src_credit_o,
   output logic                      tx_o,
   input  logic                      credit_i,
   output logic [FLIT_SIZE-1:0]      data_o
`ifdef MULTI_SRC_INJECTOR_STATS_EN
   ,
   output logic [N_SRC*32-1:0]       pkt_count_o
`endif
);

   localparam int GW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

   inj_state_t     state;
   inj_state_t     state_nxt;
   logic [GW-1:0]  grant;
   logic [GW-1:0]  grant_nxt;
   logic [GW-1:0]  rr_ptr;
   logic [GW-1:0]  rr_nxt;
   logic [GW-1:0]  sel;
   logic           found;
   logic           xfer;
   logic [FLIT_SIZE:0] head [N_SRC];
   logic [FLIT_SIZE:0] head_sel;
   logic [N_SRC-1:0]   empty;
   logic [N_SRC-1:0]   full;
   logic [N_SRC-1:0]   pop;

   assign src_credit_o = ~full;
   assign head_sel     = head[grant];
   assign xfer         = tx_o && credit_i;
   assign data_o       = tx_o ? head_sel[FLIT_SIZE-1:0] : '0;

   for (genvar g = 0; g < N_SRC; g++) begin : g_src
      assign pop[g] = xfer && (grant == GW'(g));

      inj_fifo #(
         .WIDTH (FLIT_SIZE + 1),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .push_i  (src_tx_i[g]),
         .din_i   ({src_eop_i[g], src_data_i[g*FLIT_SIZE +: FLIT_SIZE]}),
         .pop_i   (pop[g]),
         .dout_o  (head[g]),
         .empty_o (empty[g]),
         .full_o  (full[g])
      );

`ifdef MULTI_SRC_INJECTOR_STATS_EN
      logic [31:0] cnt;
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) cnt <= '0;
         else if (pop[g] && head[g][FLIT_SIZE]) cnt <= cnt + 1'b1;
      end
      assign pkt_count_o[g*32 +: 32] = cnt;
`endif
   end

   // The grant is locked for a whole packet; an empty granted FIFO
   // just stalls the port so packets never interleave.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      rr_nxt    = rr_ptr;
      tx_o      = 1'b0;
      found     = 1'b0;
      sel       = '0;
      unique case (state)
         IDLE: begin
            for (int i = 1; i <= N_SRC; i++) begin
               sel = GW'((int'(rr_ptr) + i) % N_SRC);
               if (!found && !empty[sel]) begin
                  found     = 1'b1;
                  grant_nxt = sel;
               end
            end
            if (found) state_nxt = SEND;
         end
         SEND: begin
            tx_o = !empty[grant];
            if (tx_o && credit_i && head_sel[FLIT_SIZE]) begin
               rr_nxt    = grant;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state  <= IDLE;
         grant  <= '0;
         rr_ptr <= GW'(N_SRC - 1);
      end else begin
         state  <= state_nxt;
         grant  <= grant_nxt;
         rr_ptr <= rr_nxt;
      end
   end

endmodule

// File: tb/tb_multi_src_injector.sv
// Self-checking bench for multi_src_injector: vector table, directed corner
// sequences and randomized traffic against a packet-level reference model.
module tb_multi_src_injector;

   localparam int N = 3;
   localparam int W = 32;
   localparam int D = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0]   src_tx = '0;
   logic [N-1:0]   src_eop = '0;
   logic [N*W-1:0] src_data = '0;
   logic [N-1:0]   src_credit;
   logic           tx;
   logic           credit = 1'b0;
   logic [W-1:0]   data;
`ifdef MULTI_SRC_INJECTOR_STATS_EN
   logic [N*32-1:0] pkt_count;
`endif

   multi_src_injector #(
      .N_SRC      (N),
      .FLIT_SIZE  (W),
      .FIFO_DEPTH (D)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .src_tx_i     (src_tx),
      .src_eop_i    (src_eop),
      .src_data_i   (src_data),
      .src_credit_o (src_credit),
      .tx_o         (tx),
      .credit_i     (credit),
      .data_o       (data)
`ifdef MULTI_SRC_INJECTOR_STATS_EN
      ,
      .pkt_count_o  (pkt_count)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [W:0]   q [N][$];
   logic [W-1:0] noc_log [$];
   logic [W-1:0] exp_log [$];
   bit           in_pkt;
   bit           prev_in_pkt;
   int           cur;
   int           last;
   bit [N-1:0]   prev_ne;
   int           eop_cnt [N];

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic int rr_first(bit [N-1:0] ne, int from);
      for (int i = 1; i <= N; i++) begin
         if (ne[(from + i) % N]) return (from + i) % N;
      end
      return 0;
   endfunction

   // Reference model: per-source flit queues plus packet ownership of the port.
   // A source is granted in an idle cycle and its first flit shows the cycle after.
   always @(negedge clk) begin : model
      bit [N-1:0] ne;
      bit [N-1:0] ecr;
      int         sz [N];
      bit         etx;
      int         s;
      logic [W:0] f;
      if (rst) begin
         for (int k = 0; k < N; k++) begin
            q[k].delete();
            eop_cnt[k] = 0;
         end
         in_pkt = 0;
         prev_in_pkt = 0;
         last = N - 1;
         cur = 0;
         prev_ne = '0;
         chk("rst_tx", tx, 0);
         chk("rst_data", data, 0);
         chk("rst_credit", src_credit, {N{1'b1}});
`ifdef MULTI_SRC_INJECTOR_STATS_EN
         chk("rst_pkt_count", pkt_count, 0);
`endif
      end else begin
         for (int k = 0; k < N; k++) begin
            sz[k]  = q[k].size();
            ne[k]  = sz[k] > 0;
            ecr[k] = sz[k] < D;
         end
         chk("credit", src_credit, ecr);
         etx = 0;
         s = cur;
         if (in_pkt) etx = ne[cur];
         else if (!prev_in_pkt && prev_ne != '0) begin
            s = rr_first(prev_ne, last);
            etx = 1;
         end
         chk("tx", tx, etx);
         if (etx) chk("data", data, q[s][0][W-1:0]);
         else chk("idle_data", data, 0);
         if (etx && !in_pkt) begin
            in_pkt = 1;
            cur = s;
         end
         prev_in_pkt = in_pkt;
         if (etx && credit) begin
            f = q[cur].pop_front();
            noc_log.push_back(f[W-1:0]);
            if (f[W]) begin
               in_pkt = 0;
               last = cur;
               eop_cnt[cur]++;
            end
         end
         prev_ne = ne;
         for (int k = 0; k < N; k++) begin
            if (src_tx[k] && sz[k] < D)
               q[k].push_back({src_eop[k], src_data[k*W +: W]});
         end
`ifdef MULTI_SRC_INJECTOR_STATS_EN
         for (int k = 0; k < N; k++)
            chk("pkt_count", pkt_count[k*32 +: 32], 32'(eop_cnt[k]));
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      src_tx  = '0;
      src_eop = '0;
   endtask

   task automatic wr(int k, logic [W-1:0] d, bit e);
      src_tx[k] = 1'b1;
      src_eop[k] = e;
      src_data[k*W +: W] = d;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst = 1'b1;
      src_tx = '0;
      src_eop = '0;
      credit = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      noc_log.delete();
   endtask

   task automatic chk_log(string name);
      chk({name, "_len"}, noc_log.size(), exp_log.size());
      for (int i = 0; i < exp_log.size() && i < noc_log.size(); i++)
         chk($sformatf("%s_%0d", name, i), noc_log[i], exp_log[i]);
   endtask

   typedef struct {
      bit         wv;
      logic [W-1:0] d;
      bit         e;
      bit         cr;
      bit         exp_tx;
      logic [W-1:0] exp_d;
   } vec_t;

   vec_t tbl [7];

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{1'b1, 32'hA0, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[1] = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b0, 32'h0};
      tbl[2] = '{1'b1, 32'hA2, 1'b1, 1'b1, 1'b1, 32'hA0};
      tbl[3] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'hA1};
      tbl[4] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b1, 32'hA2};
      tbl[5] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0};
      tbl[6] = '{1'b0, 32'h0,  1'b0, 1'b1, 1'b0, 32'h0};

      // single source packet
      do_reset();
      for (int i = 0; i < 7; i++) begin
         step();
         if (tbl[i].wv) wr(0, tbl[i].d, tbl[i].e);
         credit = tbl[i].cr;
         @(negedge clk);
         chk($sformatf("vec%0d_tx", i), tx, tbl[i].exp_tx);
         chk($sformatf("vec%0d_data", i), data, tbl[i].exp_d);
      end
      exp_log = '{32'hA0, 32'hA1, 32'hA2};
      chk_log("single");

      // fairness between two sources
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step();
         wr(0, 32'h10 + i, i[0]);
         wr(1, 32'h20 + i, i[0]);
      end
      step();
      credit = 1'b1;
      repeat (20) step();
      exp_log = '{32'h10, 32'h11, 32'h20, 32'h21,
                  32'h12, 32'h13, 32'h22, 32'h23};
      chk_log("fair");

      // backpressure mid-packet
      do_reset();
      for (int i = 0; i < 4; i++) begin
         step();
         wr(0, 32'h40 + i, i == 3);
      end
      step();
      step();
      credit = 1'b1;
      step();
      credit = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_tx", tx, 1);
         chk("bp_data", data, 32'h41);
         step();
      end
      credit = 1'b1;
      repeat (10) step();
      exp_log = '{32'h40, 32'h41, 32'h42, 32'h43};
      chk_log("bp");

      // full FIFO drops the ninth write
      do_reset();
      for (int i = 0; i < 9; i++) begin
         step();
         wr(0, 32'h30 + i, i >= 7);
         @(negedge clk);
         chk($sformatf("full_credit_%0d", i), src_credit[0], i < 8);
      end
      step();
      chk("full_credit_hold", src_credit[0], 0);
      credit = 1'b1;
      repeat (20) step();
      exp_log = '{32'h30, 32'h31, 32'h32, 32'h33,
                  32'h34, 32'h35, 32'h36, 32'h37};
      chk_log("full");
      chk("full_credit_back", src_credit[0], 1);

      // starved packet keeps the port
      do_reset();
      credit = 1'b1;
      step();
      wr(1, 32'h50, 1'b0);
      repeat (3) step();
      wr(0, 32'h60, 1'b0);
      step();
      wr(0, 32'h61, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step();
         @(negedge clk);
         chk("starve_tx", tx, 0);
      end
      step();
      wr(1, 32'h51, 1'b1);
      repeat (12) step();
      exp_log = '{32'h50, 32'h51, 32'h60, 32'h61};
      chk_log("starve");

      // reset in the middle of a packet
      do_reset();
      credit = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         wr(0, 32'h70 + i, i == 3);
      end
      step();
      chk("mid_sent", noc_log.size(), 2);
      rst = 1'b1;
      #1;
      chk("mid_rst_tx", tx, 0);
      chk("mid_rst_data", data, 0);
      chk("mid_rst_credit", src_credit, {N{1'b1}});
      repeat (2) step();
      rst = 1'b0;
      noc_log.delete();
      step();
      wr(0, 32'h80, 1'b0);
      step();
      wr(0, 32'h81, 1'b1);
      repeat (10) step();
      exp_log = '{32'h80, 32'h81};
      chk_log("after_rst");

      // randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         step();
         for (int k = 0; k < N; k++)
            if ($urandom_range(3) == 0)
               wr(k, $urandom, $urandom_range(2) == 0);
         credit = $urandom_range(9) < 7;
      end
      for (int c = 0; c < 50; c++) begin
         step();
         credit = 1'b1;
         for (int k = 0; k < N; k++)
            if ($urandom_range(1) == 0) wr(k, $urandom, 1'b1);
      end
      repeat (300) step();
      for (int k = 0; k < N; k++)
         chk($sformatf("drain_empty_%0d", k), q[k].size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/multi_src_injector.md
MULTI_SRC_INJECTOR -- requirements
Module: multi_src_injector

Interface
REQ-001 SHALL have parameter N_SRC, default 2: number of source channels, range 1..16.
REQ-002 SHALL have parameter FLIT_SIZE, default 32: flit width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 8: flits per source FIFO, a power of two, at least 2.
REQ-004 SHALL have port clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port src_tx_i, input, N_SRC bits: per-source flit valid.
REQ-007 SHALL have port src_eop_i, input, N_SRC bits: per-source last-flit-of-packet marker.
REQ-008 SHALL have port src_data_i, input, N_SRC*FLIT_SIZE bits: per-source flit; source k occupies bits [k*FLIT_SIZE +: FLIT_SIZE].
REQ-009 SHALL have port src_credit_o, output, N_SRC bits: per-source space available.
REQ-010 SHALL have port tx_o, output, 1 bit: NoC flit valid.
REQ-011 SHALL have port credit_i, input, 1 bit: NoC credit.
REQ-012 SHALL have port data_o, output, FLIT_SIZE bits: NoC flit.

Function
REQ-013 SHALL accept a source write only on a cycle with src_tx_i[k]=1 and src_credit_o[k]=1; src_tx_i[k] with credit low SHALL be ignored.
REQ-014 SHALL store each accepted flit with its eop bit in FIFO k; src_credit_o[k] SHALL be 0 when count==FIFO_DEPTH and 1 otherwise (combinational from count).
REQ-015 SHALL complete a NoC transfer only on a cycle with tx_o=1 and credit_i=1; tx_o SHALL NOT depend combinationally on credit_i.
REQ-016 SHALL use FSM states IDLE and SEND.
REQ-017 In IDLE: tx_o=0; if any FIFO is non-empty, grant the first non-empty source after rr_ptr (round-robin, wrapping N_SRC-1 to 0), register it, and go to SEND at the next edge.
REQ-018 In SEND: tx_o = FIFO[grant] non-empty, data_o = FIFO[grant] head; on a transfer whose eop=1, set rr_ptr=grant and return to IDLE.
REQ-019 SHALL never interleave packets: in SEND with FIFO[grant] empty, tx_o=0 and the state stays SEND.
REQ-020 SHALL allow simultaneous push and pop on one FIFO in the same cycle, including at count==FIFO_DEPTH-1 and count==1; count stays unchanged.
REQ-021 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH.
REQ-022 data_o SHALL be 0 whenever tx_o=0.
REQ-023 Minimum packet latency SHALL be: flit written at edge n appears on tx_o no earlier than cycle n+2 (one IDLE grant cycle).
REQ-024 A one-flit packet (eop on first flit) SHALL be legal.

Reset
REQ-025 rst_i=1 SHALL asynchronously: empty all FIFOs, set state=IDLE, grant=0, rr_ptr=N_SRC-1 (source 0 wins first), tx_o=0, data_o=0, src_credit_o=all ones.
REQ-026 Reset mid-packet SHALL discard the partial packet; after release the injector SHALL restart from IDLE with no residual flits.

Configuration
REQ-027 With macro MULTI_SRC_INJECTOR_STATS_EN defined, the block SHALL add output pkt_count_o (N_SRC*32 bits): per-source count of eop flits transferred on the NoC, wrapping at 2^32, cleared by rst_i.
REQ-028 Without MULTI_SRC_INJECTOR_STATS_EN, the port and the counters SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 PhiversPkg SHALL hold the FSM state typedef (inj_state_t: IDLE, SEND) and the default FLIT_SIZE constant.
REQ-030 The per-source buffer SHALL be sub-module inj_fifo (parameters FLIT_SIZE+1 width, FIFO_DEPTH), instantiated N_SRC times in a generate loop.

Verification
REQ-031 Single source: src0 writes 3 flits 0xA0,0xA1,0xA2 (eop on 0xA2), credit_i=1 -> tx_o is 1 for exactly 3 consecutive cycles, data_o=0xA0,0xA1,0xA2, then state IDLE.
REQ-032 Fairness: src0 and src1 each hold two 2-flit packets (0x1x / 0x2x) -> NoC order is src0 pkt, src1 pkt, src0 pkt, src1 pkt, with no flit interleaving.
REQ-033 Backpressure: credit_i=0 for 10 cycles mid-packet -> tx_o held, data_o stable, no flit lost or duplicated after credit returns.
REQ-034 Full FIFO: FIFO_DEPTH=8, credit_i=0, src0 writes 9 flits -> src_credit_o[0]=0 after the 8th, the 9th is ignored, exactly 8 flits emerge later.
REQ-035 Starved packet: src1 sends the head flit, then stalls 5 cycles while src0 has data -> tx_o=0 during the stall, src0 is not served until src1 eop.
REQ-036 Reset mid-packet: assert rst_i after 2 of 4 flits -> tx_o=0 immediately, all src_credit_o=1, and the next packet emerges cleanly; with STATS_EN, pkt_count_o=0.
